keystream_block_scheduler: RTL and testbench

- Drives the block-counter interface from the producing side: issues ChaCha20 block computations for a message of given byte length and advances `blocksproduced` once per block consumed downstream.
- Reads back the counter value `block_ctr`, forms the per-block counter for the ChaCha20 core, and forwards each 512-bit keystream block to the XOR/encrypt stage with a valid/ready handshake.
- Flags counter-space overflow and counter desynchronisation.

---
 rtl/chacha_pkg.sv | 43 ++++
 rtl/keystream_block_scheduler.sv | 129 ++++++++++++
 tb/tb_keystream_block_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha20 keystream scheduler: word/block types, FSM states,
// and the message-length admission check.
package chacha_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [511:0] block_t;

    localparam int unsigned BLOCK_BYTES = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CORE,
        ST_PRESENT,
        ST_SETTLE,
        ST_DONE,
        ST_ERR
    } sched_state_t;

    typedef enum logic [1:0] {
        LEN_ZERO,
        LEN_OK,
        LEN_OVF
    } len_chk_t;

    // A message fits only if every block counter from ctr_init upward stays below 2^32.
    function automatic len_chk_t len_check(
        input logic        is_zero,
        input logic [63:0] blocks,
        input word_t       ctr_init
    );
        logic [64:0] limit;
        limit = 65'h1_0000_0000 - {33'b0, ctr_init};
        if (is_zero) begin
            return LEN_ZERO;
        end
        if ({1'b0, blocks} > limit) begin
            return LEN_OVF;
        end
        return LEN_OK;
    endfunction

endpackage

// File: rtl/keystream_block_scheduler.sv
// Issues one ChaCha20 block per message block and streams it out on valid/ready;
// first core_start one cycle after start, ks_data held until ks_ready, one SETTLE cycle per block.
module keystream_block_scheduler
    import chacha_pkg::*;
#(
    parameter int unsigned COUNTER_INIT = 1,
    parameter int unsigned LEN_W        = 38
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  word_t            block_ctr,
    output word_t            blocksproduced,
    output logic             core_start,
    output word_t            core_counter,
    input  logic             core_done,
    input  block_t           core_block,
    output logic             ks_valid,
    input  logic             ks_ready,
    output block_t           ks_data,
    output logic             ks_last,
    output logic [6:0]       ks_bytes,
    output logic             busy,
    output logic             done,
    output logic             err_overflow,
    output logic             err_sync
);

    localparam int unsigned REM_W = LEN_W - 5;

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [REM_W-1:0] rem;
    logic [5:0]       tail;
    logic [REM_W-1:0] msg_blocks;
    len_chk_t         len_status;
    logic             ctr_in_sync;
    logic             last_block;
    logic             xfer;

    // ceil(msg_len / 64) without a carry-out adder: whole blocks plus one for any tail.
    assign msg_blocks  = REM_W'(msg_len >> 6) + REM_W'(|msg_len[5:0]);
    assign len_status  = len_check(msg_len == '0, 64'(msg_blocks), word_t'(COUNTER_INIT));
    assign ctr_in_sync = (block_ctr == blocksproduced);
    assign last_block  = (rem == REM_W'(1));
    assign xfer        = (state == ST_PRESENT) && ks_ready;

    assign ks_valid = (state == ST_PRESENT);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_comb begin
        state_nxt    = state;
        core_start   = 1'b0;
        core_counter = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (len_status)
                        LEN_ZERO: state_nxt = ST_DONE;
                        LEN_OVF:  state_nxt = ST_ERR;
                        default:  state_nxt = ST_ISSUE;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (ctr_in_sync) begin
                    core_start   = 1'b1;
                    core_counter = word_t'(COUNTER_INIT) + block_ctr;
                    state_nxt    = ST_WAIT_CORE;
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            ST_WAIT_CORE: begin
                if (core_done) begin
                    state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ks_ready) begin
                    state_nxt = last_block ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: state_nxt = ST_ISSUE;
            ST_DONE:   state_nxt = ST_IDLE;
            ST_ERR:    state_nxt = ST_ERR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state          <= ST_IDLE;
            rem            <= '0;
            tail           <= '0;
            blocksproduced <= '0;
            ks_data        <= '0;
            ks_last        <= 1'b0;
            ks_bytes       <= '0;
            err_overflow   <= 1'b0;
            err_sync       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                rem  <= msg_blocks;
                tail <= msg_len[5:0];
                if (len_status == LEN_OVF) begin
                    err_overflow <= 1'b1;
                end
            end
            if (state == ST_ISSUE && !ctr_in_sync) begin
                err_sync <= 1'b1;
            end
            if (state == ST_WAIT_CORE && core_done) begin
                ks_data <= core_block;
                ks_last <= last_block;
                // Only the final block can be short; a zero tail means it is full.
                ks_bytes <= (last_block && tail != 6'd0) ? {1'b0, tail} : 7'(BLOCK_BYTES);
            end
            if (xfer) begin
                blocksproduced <= blocksproduced + 32'd1;
                rem            <= rem - REM_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_keystream_block_scheduler.sv
// Bench for keystream_block_scheduler: message-level reference model, attached block counter,
// randomized core latency and downstream ready.
module tb_keystream_block_scheduler;
    import chacha_pkg::*;

    localparam int unsigned CI = 1;
    localparam int unsigned LW = 38;

    typedef struct packed {
        logic [6:0] bytes;
        logic       last;
    } ks_exp_t;

    logic          clk = 1'b0;
    logic          init;
    logic          start;
    logic [LW-1:0] msg_len;
    word_t         block_ctr;
    word_t         blocksproduced;
    logic          core_start;
    word_t         core_counter;
    logic          core_done;
    block_t        core_block;
    logic          ks_valid;
    logic          ks_ready;
    block_t        ks_data;
    logic          ks_last;
    logic [6:0]    ks_bytes;
    logic          busy;
    logic          done;
    logic          err_overflow;
    logic          err_sync;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;
    logic freeze = 1'b0;
    int   ready_mode = 0;
    int   core_lat_extra = 0;
    logic core_slow = 1'b0;

    word_t      obs_ctr[$];
    logic [6:0] obs_bytes[$];
    logic       obs_last[$];

    keystream_block_scheduler #(.COUNTER_INIT(CI), .LEN_W(LW)) dut (
        .clk(clk), .init(init), .start(start), .msg_len(msg_len),
        .block_ctr(block_ctr), .blocksproduced(blocksproduced),
        .core_start(core_start), .core_counter(core_counter),
        .core_done(core_done), .core_block(core_block),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .ks_last(ks_last), .ks_bytes(ks_bytes), .busy(busy), .done(done),
        .err_overflow(err_overflow), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    // Block counter: follows blocksproduced one cycle later unless frozen.
    always @(posedge clk) begin
        if (init) block_ctr <= '0;
        else if (!freeze) block_ctr <= blocksproduced;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ChaCha core stand-in: answers each core_start with a fresh random block after 1..N cycles.
    initial begin
        core_done  = 1'b0;
        core_block = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_start) begin
                repeat (1 + (core_slow ? 8 : $urandom_range(0, core_lat_extra))) @(negedge clk);
                for (int w = 0; w < 16; w++) core_block[w*32 +: 32] = $urandom;
                core_done = 1'b1;
            end
        end
    end

    initial begin
        ks_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ks_ready = 1'b1;
                1:       ks_ready = 1'b0;
                default: ks_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model and per-cycle comparison.
    initial begin : compare_proc
        ks_exp_t         e;
        logic            done_now;
        logic            model_idle;
        logic            done_exp;
        logic            exp_ovf;
        logic            exp_sync;
        word_t           exp_bp;
        int              sync_cd;
        logic            prev_stall;
        block_t          prev_data;
        logic            prev_last;
        logic [6:0]      prev_bytes;
        longint unsigned len_m;
        longint unsigned total_m;
        word_t           exp_ctr_q[$];
        ks_exp_t         exp_ks_q[$];
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                model_idle = 1'b1; done_exp = 1'b0; exp_ovf = 1'b0; exp_sync = 1'b0;
                exp_bp = '0; sync_cd = 0; prev_stall = 1'b0;
                exp_ctr_q.delete();
                exp_ks_q.delete();
            end else begin
                if (sync_cd > 0) begin
                    sync_cd--;
                    if (sync_cd == 0) exp_sync = 1'b1;
                end
                chk("blocksproduced", 64'(blocksproduced), 64'(exp_bp));
                chk("done", 64'(done), 64'(done_exp));
                chk("err_overflow", 64'(err_overflow), 64'(exp_ovf));
                chk("err_sync", 64'(err_sync), 64'(exp_sync));
                chk("busy", 64'(busy), 64'(!model_idle));
                if (prev_stall) begin
                    chk("hold_valid", 64'(ks_valid), 64'(1));
                    chk("hold_data", 64'(ks_data == prev_data), 64'(1));
                    chk("hold_last", 64'(ks_last), 64'(prev_last));
                    chk("hold_bytes", 64'(ks_bytes), 64'(prev_bytes));
                end
                if (core_start) begin
                    if (exp_ctr_q.size() == 0) chk("core_start_unexpected", 64'(core_start), 64'(0));
                    else chk("core_counter", 64'(core_counter), 64'(exp_ctr_q.pop_front()));
                    obs_ctr.push_back(core_counter);
                end
                done_now = done_exp;
                done_exp = 1'b0;
                if (ks_valid && ks_ready) begin
                    if (exp_ks_q.size() == 0) begin
                        chk("ks_valid_unexpected", 64'(ks_valid), 64'(0));
                    end else begin
                        e = exp_ks_q.pop_front();
                        chk("ks_bytes", 64'(ks_bytes), 64'(e.bytes));
                        chk("ks_last", 64'(ks_last), 64'(e.last));
                        if (e.last) done_exp = 1'b1;
                        else if (freeze) sync_cd = 3;
                    end
                    chk("ks_data", 64'(ks_data == core_block), 64'(1));
                    obs_bytes.push_back(ks_bytes);
                    obs_last.push_back(ks_last);
                    exp_bp = exp_bp + 32'd1;
                end
                if (start && model_idle) begin
                    len_m      = 64'(msg_len);
                    total_m    = (len_m + 63) / 64;
                    model_idle = 1'b0;
                    if (len_m == 0) begin
                        done_exp = 1'b1;
                    end else if (total_m > 64'h1_0000_0000 - 64'(CI)) begin
                        exp_ovf = 1'b1;
                    end else begin
                        for (longint unsigned i = 0; i < total_m; i++) begin
                            // A frozen counter only matches blocksproduced while both are 0.
                            if (freeze && (64'(exp_bp) + i) != 0) break;
                            exp_ctr_q.push_back(word_t'(64'(CI) + 64'(exp_bp) + i));
                            e.last  = (i == total_m - 1);
                            e.bytes = (e.last && (len_m % 64) != 0) ? 7'(len_m % 64) : 7'd64;
                            exp_ks_q.push_back(e);
                        end
                    end
                end
                if (done_now) model_idle = 1'b1;
                prev_stall = ks_valid && !ks_ready;
                prev_data  = ks_data;
                prev_last  = ks_last;
                prev_bytes = ks_bytes;
            end
        end
    end

    task automatic do_init();
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        init  = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        init   = 1'b0;
        chk_en = 1'b1;
        obs_ctr.delete();
        obs_bytes.delete();
        obs_last.delete();
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_bp"}, 64'(blocksproduced), 64'(0));
        chk({tag, "_core_start"}, 64'(core_start), 64'(0));
        chk({tag, "_core_counter"}, 64'(core_counter), 64'(0));
        chk({tag, "_ks_valid"}, 64'(ks_valid), 64'(0));
        chk({tag, "_ks_data"}, 64'(ks_data == '0), 64'(1));
        chk({tag, "_ks_last"}, 64'(ks_last), 64'(0));
        chk({tag, "_ks_bytes"}, 64'(ks_bytes), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err_overflow"}, 64'(err_overflow), 64'(0));
        chk({tag, "_err_sync"}, 64'(err_sync), 64'(0));
    endtask

    task automatic send(input logic [LW-1:0] len);
        @(posedge clk);
        #1;
        start   = 1'b1;
        msg_len = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        chk("idle_within_budget", 64'(busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        word_t      exp_c[3];
        logic [6:0] exp_b[3];
        logic       exp_l[3];
        int         n;
        logic [LW-1:0] len;
        exp_c = '{32'd1, 32'd2, 32'd3};
        exp_b = '{7'd64, 7'd64, 7'd2};
        exp_l = '{1'b0, 1'b0, 1'b1};
        init = 1'b1;
        start = 1'b0;
        msg_len = '0;

        do_init();
        check_zero("reset");

        // 130 bytes: three blocks, 64/64/2.
        core_lat_extra = 2;
        send(38'd130);
        wait_idle(200);
        chk("m130_core_starts", 64'(obs_ctr.size()), 64'(3));
        chk("m130_xfers", 64'(obs_bytes.size()), 64'(3));
        if (obs_ctr.size() == 3 && obs_bytes.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("m130_counter", 64'(obs_ctr[i]), 64'(exp_c[i]));
                chk("m130_bytes", 64'(obs_bytes[i]), 64'(exp_b[i]));
                chk("m130_last", 64'(obs_last[i]), 64'(exp_l[i]));
            end
        end
        chk("m130_bp", 64'(blocksproduced), 64'(3));

        // Zero-length message: done right after accept, nothing issued.
        obs_ctr.delete();
        obs_bytes.delete();
        send('0);
        @(negedge clk);
        chk("len0_done", 64'(done), 64'(1));
        repeat (3) @(negedge clk);
        chk("len0_no_core", 64'(obs_ctr.size()), 64'(0));
        chk("len0_bp", 64'(blocksproduced), 64'(3));

        // Downstream stall on a single full block.
        obs_bytes.delete();
        obs_last.delete();
        ready_mode = 1;
        send(38'd64);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ks_valid && n < 50);
        chk("stall_valid_seen", 64'(ks_valid), 64'(1));
        repeat (5) begin
            @(negedge clk);
            chk("stall_bp", 64'(blocksproduced), 64'(3));
            chk("stall_last", 64'(ks_last), 64'(1));
            chk("stall_bytes", 64'(ks_bytes), 64'(64));
        end
        ready_mode = 0;
        wait_idle(50);
        chk("stall_bp_after", 64'(blocksproduced), 64'(4));

        // Randomized messages, random ready, stray starts while busy.
        ready_mode = 2;
        core_lat_extra = 3;
        for (int m = 0; m < 30; m++) begin
            case ($urandom_range(0, 3))
                0:       len = LW'(64 * $urandom_range(1, 4));
                1:       len = LW'($urandom_range(1, 3));
                default: len = LW'($urandom_range(1, 320));
            endcase
            send(len);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                send(LW'($urandom_range(0, 200)));
            end
            wait_idle(500);
        end
        ready_mode = 0;

        // Counter-space overflow: 2^38-1 bytes needs 2^32 blocks.
        do_init();
        send('1);
        @(negedge clk);
        chk("ovf_flag", 64'(err_overflow), 64'(1));
        chk("ovf_no_core", 64'(core_start), 64'(0));
        repeat (4) @(negedge clk);
        send(38'd64);
        repeat (10) @(negedge clk);
        chk("ovf_sticky", 64'(err_overflow), 64'(1));
        chk("ovf_busy", 64'(busy), 64'(1));
        chk("ovf_ignored_start", 64'(obs_ctr.size()), 64'(0));
        do_init();
        check_zero("ovf_cleared");

        // init while waiting on the core aborts the message.
        core_slow = 1'b1;
        send(38'd64);
        n = 0;
        while (!core_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_core_start_seen", 64'(core_start), 64'(1));
        do_init();
        check_zero("abort");
        repeat (15) @(negedge clk);
        core_slow = 1'b0;
        obs_ctr.delete();
        send(38'd64);
        wait_idle(50);
        chk("abort_then_count", 64'(obs_ctr.size()), 64'(1));
        if (obs_ctr.size() == 1) chk("abort_then_counter", 64'(obs_ctr[0]), 64'(1));
        chk("abort_then_bp", 64'(blocksproduced), 64'(1));

        // Frozen block counter: second ISSUE sees a mismatch.
        do_init();
        freeze = 1'b1;
        send(38'd128);
        repeat (30) @(negedge clk);
        chk("sync_flag", 64'(err_sync), 64'(1));
        chk("sync_core_starts", 64'(obs_ctr.size()), 64'(1));
        chk("sync_bp", 64'(blocksproduced), 64'(1));
        chk("sync_busy", 64'(busy), 64'(1));
        freeze = 1'b0;
        do_init();
        check_zero("sync_cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
